// File: rtl/baccarat_deal_ctrl_if.sv
// Signal bundle between the baccarat deal controller and the datapath:
// scores in, card-register load strobes and result lights out.
interface baccarat_deal_ctrl_if;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [3:0] pcard3;
  logic       load_pcard1;
  logic       load_pcard2;
  logic       load_pcard3;
  logic       load_dcard1;
  logic       load_dcard2;
  logic       load_dcard3;
  logic       player_win_light;
  logic       dealer_win_light;
  logic       done;

  modport master (
    input  pscore, dscore, pcard3,
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    output player_win_light, dealer_win_light, done
  );

  modport slave (
    output pscore, dscore, pcard3,
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    input  player_win_light, dealer_win_light, done
  );
endinterface

// File: rtl/baccarat_deal_ctrl.sv
// Baccarat dealing sequencer: strobes one card register per clock, applies the
// natural and third-card rules, then latches the win lights until reset.
module baccarat_deal_ctrl (
  input logic                         slow_clock,
  input logic                         reset,
  baccarat_deal_ctrl_if.master        bus
);

  typedef enum logic [3:0] {
    DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, EVAL4,
    DEAL_P3, EVAL_B, DEAL_D3, SCORE, DONE
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_playerWin;
  logic       r_dealerWin;
  logic [5:0] w_strobes;
  logic       w_done;
  logic [3:0] w_thirdVal;
  logic [9:0] w_drawMask;
  logic       w_bankerDraws;

  always_ff @(posedge slow_clock) begin
    if (reset) r_state <= DEAL_P1;
    else       r_state <= w_next;
  end

  // Lights are only ever written on the edge leaving SCORE; ties light both.
  always_ff @(posedge slow_clock) begin
    if (reset) begin
      r_playerWin <= 1'b0;
      r_dealerWin <= 1'b0;
    end else if (r_state == SCORE) begin
      r_playerWin <= (bus.pscore >= bus.dscore);
      r_dealerWin <= (bus.dscore >= bus.pscore);
    end
  end

  // Banker rule as a per-score mask over the player's third-card value 0..9.
  always_comb begin
    w_thirdVal = ((bus.pcard3 >= 4'd1) && (bus.pcard3 <= 4'd9)) ? bus.pcard3 : 4'd0;
    w_drawMask = 10'b0;
    case (bus.dscore)
      4'd0, 4'd1, 4'd2: w_drawMask = 10'b11_1111_1111;
      4'd3:             w_drawMask = 10'b10_1111_1111;
      4'd4:             w_drawMask = 10'b00_1111_1100;
      4'd5:             w_drawMask = 10'b00_1111_0000;
      4'd6:             w_drawMask = 10'b00_1100_0000;
      default:          w_drawMask = 10'b0;
    endcase
    w_bankerDraws = w_drawMask[w_thirdVal];
  end

  always_comb begin
    w_next    = r_state;
    w_strobes = 6'b0;
    w_done    = 1'b0;
    case (r_state)
      DEAL_P1: begin w_strobes[0] = 1'b1; w_next = DEAL_D1; end
      DEAL_D1: begin w_strobes[3] = 1'b1; w_next = DEAL_P2; end
      DEAL_P2: begin w_strobes[1] = 1'b1; w_next = DEAL_D2; end
      DEAL_D2: begin w_strobes[4] = 1'b1; w_next = EVAL4;   end
      EVAL4: begin
        if ((bus.pscore >= 4'd8) || (bus.dscore >= 4'd8)) w_next = SCORE;
        else if (bus.pscore <= 4'd5)                      w_next = DEAL_P3;
        else if (bus.dscore <= 4'd5)                      w_next = DEAL_D3;
        else                                              w_next = SCORE;
      end
      DEAL_P3: begin w_strobes[2] = 1'b1; w_next = EVAL_B; end
      EVAL_B:  w_next = w_bankerDraws ? DEAL_D3 : SCORE;
      DEAL_D3: begin w_strobes[5] = 1'b1; w_next = SCORE; end
      SCORE:   w_next = DONE;
      DONE:    begin w_done = 1'b1; w_next = DONE; end
      default: w_next = DEAL_P1;
    endcase
    // Reset cycles must never emit a strobe or a stale done.
    if (reset) begin
      w_strobes = 6'b0;
      w_done    = 1'b0;
    end
  end

  assign bus.load_pcard1      = w_strobes[0];
  assign bus.load_pcard2      = w_strobes[1];
  assign bus.load_pcard3      = w_strobes[2];
  assign bus.load_dcard1      = w_strobes[3];
  assign bus.load_dcard2      = w_strobes[4];
  assign bus.load_dcard3      = w_strobes[5];
  assign bus.done             = w_done;
  assign bus.player_win_light = r_playerWin;
  assign bus.dealer_win_light = r_dealerWin;

endmodule

// File: tb/tb_baccarat_deal_ctrl.sv
// Directed bench for baccarat_deal_ctrl with a small card-register datapath
// model that captures dealt cards on the controller's load strobes.
module tb_baccarat_deal_ctrl;

  logic slow_clock;
  logic reset;
  int   compared;
  int   mismatched;

  logic [3:0] deckP1, deckP2, deckP3, deckD1, deckD2, deckD3;
  logic [3:0] pR1, pR2, pR3, dR1, dR2, dR3;

  baccarat_deal_ctrl_if bus ();

  baccarat_deal_ctrl dut (
    .slow_clock (slow_clock),
    .reset      (reset),
    .bus        (bus)
  );

  initial begin
    slow_clock = 1'b0;
    forever #5 slow_clock = ~slow_clock;
  end

  function automatic int cardVal(input logic [3:0] rank);
    if (rank >= 4'd1 && rank <= 4'd9) return int'(rank);
    return 0;
  endfunction

  // Datapath model: registers capture the pending deck card on each strobe.
  always @(posedge slow_clock) begin
    if (reset) begin
      pR1 <= 4'd0; pR2 <= 4'd0; pR3 <= 4'd0;
      dR1 <= 4'd0; dR2 <= 4'd0; dR3 <= 4'd0;
    end else begin
      if (bus.load_pcard1) pR1 <= deckP1;
      if (bus.load_pcard2) pR2 <= deckP2;
      if (bus.load_pcard3) pR3 <= deckP3;
      if (bus.load_dcard1) dR1 <= deckD1;
      if (bus.load_dcard2) dR2 <= deckD2;
      if (bus.load_dcard3) dR3 <= deckD3;
    end
  end

  assign bus.pscore = 4'((cardVal(pR1) + cardVal(pR2) + cardVal(pR3)) % 10);
  assign bus.dscore = 4'((cardVal(dR1) + cardVal(dR2) + cardVal(dR3)) % 10);
  assign bus.pcard3 = pR3;

  function automatic logic [5:0] strobes();
    return {bus.load_pcard1, bus.load_dcard1, bus.load_pcard2,
            bus.load_dcard2, bus.load_pcard3, bus.load_dcard3};
  endfunction

  // Expected strobe pattern per cycle, ordered {p1,d1,p2,d2,p3,d3}.
  function automatic logic [5:0] expStrobe(input int n, input bit pD, input bit dD);
    case (n)
      1: return 6'b100000;
      2: return 6'b010000;
      3: return 6'b001000;
      4: return 6'b000100;
      6: return pD ? 6'b000010 : (dD ? 6'b000001 : 6'b000000);
      8: return (pD && dD) ? 6'b000001 : 6'b000000;
      default: return 6'b000000;
    endcase
  endfunction

  // Hand-written banker table, indexed by dealer score and player card rank.
  function automatic bit bankerDraws(input int ds, input int rank);
    int v;
    v = (rank >= 1 && rank <= 9) ? rank : 0;
    if (ds <= 2) return 1'b1;
    if (ds == 3) return (v != 8);
    if (ds == 4) return (v >= 2 && v <= 7);
    if (ds == 5) return (v >= 4 && v <= 7);
    if (ds == 6) return (v == 6 || v == 7);
    return 1'b0;
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input string tag,
                               input logic [3:0] p1, input logic [3:0] p2, input logic [3:0] p3,
                               input logic [3:0] d1, input logic [3:0] d2, input logic [3:0] d3,
                               input bit expP, input bit expD,
                               input bit chkLights, input bit expPL, input bit expDL);
    int doneCycle;
    deckP1 = p1; deckP2 = p2; deckP3 = p3;
    deckD1 = d1; deckD2 = d2; deckD3 = d3;
    doneCycle = (!expP && !expD) ? 7 : (!expP ? 8 : (!expD ? 9 : 10));
    @(negedge slow_clock);
    reset = 1'b1;
    #1;
    checkOutput({tag, " rst strobes"}, {2'b0, strobes()}, 8'h00);
    checkOutput({tag, " rst done"}, {7'b0, bus.done}, 8'h00);
    @(posedge slow_clock);
    #1 reset = 1'b0;
    checkOutput({tag, " rst lights"}, {6'b0, bus.player_win_light, bus.dealer_win_light}, 8'h00);
    for (int n = 1; n <= 11; n++) begin
      @(negedge slow_clock);
      checkOutput($sformatf("%s strobes c%0d", tag, n), {2'b0, strobes()}, {2'b0, expStrobe(n, expP, expD)});
      checkOutput($sformatf("%s done c%0d", tag, n), {7'b0, bus.done}, {7'b0, (n >= doneCycle)});
    end
    if (chkLights) begin
      @(negedge slow_clock);
      checkOutput({tag, " lights"}, {6'b0, bus.player_win_light, bus.dealer_win_light},
                  {6'b0, expPL, expDL});
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    deckP1 = 4'd0; deckP2 = 4'd0; deckP3 = 4'd0;
    deckD1 = 4'd0; deckD2 = 4'd0; deckD3 = 4'd0;
    repeat (2) @(posedge slow_clock);

    // Natural 8 for the player: P 4,4 vs D 2,3.
    applyStimulus("natural", 4'd4, 4'd4, 4'd5, 4'd2, 4'd3, 4'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    // Both stand on 7: tie.
    applyStimulus("tie", 4'd3, 4'd4, 4'd5, 4'd10, 4'd7, 4'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    // Player 6 stands, banker 3 draws a 5 to reach 8.
    applyStimulus("bankerDraw", 4'd2, 4'd4, 4'd5, 4'd1, 4'd2, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    // Player 0 draws a K, banker 7 stands.
    applyStimulus("playerDraw", 4'd10, 4'd10, 4'd13, 4'd3, 4'd4, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    // Both draw: player 5+4 = 9, banker 2+3 = 5.
    applyStimulus("bothDraw", 4'd2, 4'd3, 4'd4, 4'd1, 4'd1, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    // Banker rule sweep: player A,A (2) always draws; dealer K + rank ds.
    for (int ds = 0; ds <= 7; ds++) begin
      for (int r = 1; r <= 13; r++) begin
        applyStimulus($sformatf("sweep ds=%0d r=%0d", ds, r),
                      4'd1, 4'd1, 4'(r), 4'd13, (ds == 0) ? 4'd13 : 4'(ds), 4'd1,
                      1'b1, bankerDraws(ds, r), 1'b0, 1'b0, 1'b0);
      end
    end

    // Reset asserted in cycle 3 of a natural hand.
    deckP1 = 4'd4; deckP2 = 4'd4; deckD1 = 4'd2; deckD2 = 4'd3;
    @(negedge slow_clock);
    reset = 1'b1;
    @(posedge slow_clock);
    #1 reset = 1'b0;
    @(negedge slow_clock);
    @(negedge slow_clock);
    @(negedge slow_clock);
    reset = 1'b1;
    #1;
    checkOutput("midRst strobes", {2'b0, strobes()}, 8'h00);
    checkOutput("midRst done", {7'b0, bus.done}, 8'h00);
    @(posedge slow_clock);
    #1 reset = 1'b0;
    checkOutput("midRst lights", {6'b0, bus.player_win_light, bus.dealer_win_light}, 8'h00);
    @(negedge slow_clock);
    checkOutput("midRst restart", {2'b0, strobes()}, 8'h20);

    // Reset while holding a result in DONE.
    applyStimulus("preDone", 4'd4, 4'd4, 4'd5, 4'd2, 4'd3, 4'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge slow_clock);
    reset = 1'b1;
    #1;
    checkOutput("doneRst strobes", {2'b0, strobes()}, 8'h00);
    checkOutput("doneRst done", {7'b0, bus.done}, 8'h00);
    @(posedge slow_clock);
    #1 reset = 1'b0;
    checkOutput("doneRst lights", {6'b0, bus.player_win_light, bus.dealer_win_light}, 8'h00);
    @(negedge slow_clock);
    checkOutput("doneRst restart", {2'b0, strobes()}, 8'h20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
